apb_timer: RTL and testbench

APB slave peripheral that terminates transfers issued by the SoC's APB master. It provides a memory-mapped down-counting timer with a prescaler, one-shot and auto-reload modes, a sticky expiry flag and a level interrupt to the CPU. Zero or more access wait states are configurable so the master's pready handling can be exercised.

---
 rtl/apb_timer.sv | 154 +++++++++++++++
 tb/tb_apb_timer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer.sv
// APB slave down-counting timer with prescaler, one-shot/auto-reload modes,
// sticky expiry flag, level interrupt and configurable access wait states.
module apb_timer #(
   parameter int WAIT_STATES = 0,
   parameter int CNT_W       = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        psel,
   input  logic        penable,
   input  logic [31:0] paddr,
   input  logic        pwrite,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   output logic        irq
);

   localparam logic [3:0] WS         = 4'(WAIT_STATES);
   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_PRESC  = 3'd1;
   localparam logic [2:0] OFF_LOAD   = 3'd2;
   localparam logic [2:0] OFF_COUNT  = 3'd3;
   localparam logic [2:0] OFF_STATUS = 3'd4;

   logic              access;
   logic [2:0]        offset;
   logic              unmapped;
   logic              wr_en;
   logic              ctrl_wr;
   logic              presc_wr;
   logic              load_wr;
   logic              status_wr;
   logic              tick;
   logic              expire;
   logic [3:0]        wcnt;
   logic              en;
   logic              ar;
   logic              ie;
   logic              exp_flag;
   logic [15:0]       presc;
   logic [15:0]       pcnt;
   logic [CNT_W-1:0]  load;
   logic [CNT_W-1:0]  count;
   logic [31:0]       load_ext;
   logic [31:0]       count_ext;
   logic              unused_bits;

   assign access    = psel & penable;
   assign offset    = paddr[4:2];
   assign unmapped  = offset > OFF_STATUS;
   // rst_n gates pready so an in-flight transfer stalls the instant reset asserts
   assign pready    = rst_n & access & (wcnt == WS);
   assign pslverr   = pready & unmapped;
   assign wr_en     = access & pready & pwrite;
   assign ctrl_wr   = wr_en & (offset == OFF_CTRL);
   assign presc_wr  = wr_en & (offset == OFF_PRESC);
   assign load_wr   = wr_en & (offset == OFF_LOAD);
   assign status_wr = wr_en & (offset == OFF_STATUS);
   assign tick      = en & (pcnt == presc);
   assign expire    = tick & (count == '0);
   assign irq       = exp_flag & ie;
   assign unused_bits = ^{paddr[31:5], paddr[1:0], pwdata};

   // Wait counter: clears whenever the access ends, completes or is abandoned.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         wcnt <= '0;
      end else if (!access || pready) begin
         wcnt <= '0;
      end else begin
         wcnt <= wcnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en    <= 1'b0;
         ar    <= 1'b0;
         ie    <= 1'b0;
         presc <= '0;
         load  <= '0;
      end else begin
         if (ctrl_wr) begin
            en <= pwdata[0];
            ar <= pwdata[1];
            ie <= pwdata[2];
         end else if (expire && !ar) begin
            en <= 1'b0;
         end
         if (presc_wr) presc <= pwdata[15:0];
         if (load_wr)  load  <= pwdata[CNT_W-1:0];
      end
   end

   // Prescaler and counter; a LOAD write overrides a coincident tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt  <= '0;
         count <= '0;
      end else begin
         if (load_wr || (ctrl_wr && pwdata[0] && !en)) begin
            pcnt <= '0;
         end else if (en) begin
            pcnt <= tick ? '0 : pcnt + 16'd1;
         end

         if (load_wr) begin
            count <= pwdata[CNT_W-1:0];
         end else if (tick) begin
            if (count != '0) begin
               count <= count - CNT_W'(1);
            end else if (ar) begin
               count <= load;
            end
         end
      end
   end

   // Expiry is sticky; a set in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_flag <= 1'b0;
      end else if (expire) begin
         exp_flag <= 1'b1;
      end else if (status_wr && pwdata[0]) begin
         exp_flag <= 1'b0;
      end
   end

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path through the case leaves it unassigned (which infers a latch).
      load_ext                = '0;
      load_ext[CNT_W-1:0]     = load;
      count_ext               = '0;
      count_ext[CNT_W-1:0]    = count;
      prdata                  = '0;
      if (psel) begin
         case (offset)
            OFF_CTRL:   prdata = {29'b0, ie, ar, en};
            OFF_PRESC:  prdata = {16'b0, presc};
            OFF_LOAD:   prdata = load_ext;
            OFF_COUNT:  prdata = count_ext;
            OFF_STATUS: prdata = {31'b0, exp_flag};
            default:    prdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: register map, wait states, timer modes
// against an arithmetic expiry model, W1C races, protocol abort and reset.
module tb_apb_timer;

   localparam int WS = 2;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        psel    = 1'b0;
   logic        penable = 1'b0;
   logic [31:0] paddr   = '0;
   logic        pwrite  = 1'b0;
   logic [31:0] pwdata  = '0;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        irq;

   int cyc;
   int n_checks;
   int n_fail;

   apb_timer #(
      .WAIT_STATES(WS),
      .CNT_W      (32)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .psel   (psel),
      .penable(penable),
      .paddr  (paddr),
      .pwrite (pwrite),
      .pwdata (pwdata),
      .prdata (prdata),
      .pready (pready),
      .pslverr(pslverr),
      .irq    (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   // COUNT value el cycles after the enabling write, from the period rules.
   function automatic int model_count(int el, int n, int p, bit ar);
      int per;
      int ph;
      per = (n + 1) * (p + 1);
      if (!ar && el >= per) return 0;
      ph = ar ? el % per : el;
      return n - ph / (p + 1);
   endfunction

   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                            output int commit, output int waits);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
      @(posedge clk); #1;
      penable = 1'b1;
      waits = 0;
      commit = -1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (pready) begin
            commit = cyc + 1;
            break;
         end
         waits++;
      end
      if (commit < 0) check("write_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic err, output int waits);
      bit done;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
      @(posedge clk); #1;
      penable = 1'b1;
      waits = 0;
      done = 1'b0;
      data = '0;
      err = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (pready) begin
            data = prdata;
            err = pslverr;
            done = 1'b1;
            break;
         end
         waits++;
      end
      if (!done) check("read_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      int c;
      int w;
      apb_write(addr, data, c, w);
   endtask

   task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] want);
      logic [31:0] d;
      logic e;
      int w;
      apb_read(addr, d, e, w);
      check(tag, d, want);
   endtask

   // Hold a SETUP-only select on COUNT and compare it and irq each cycle.
   task automatic watch(input int t0, input int n, input int p, input bit ar,
                        input bit ie, input int samples);
      int el;
      int per;
      per = (n + 1) * (p + 1);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0C;
      for (int k = 0; k < samples; k++) begin
         @(negedge clk);
         el = cyc - t0;
         check($sformatf("count@%0d", el), prdata, 32'(model_count(el, n, p, ar)));
         check($sformatf("irq@%0d", el), 32'(irq), 32'(ie && el >= per));
      end
      psel = 1'b0;
   endtask

   task automatic wait_until(input int target);
      int guard;
      guard = 0;
      @(negedge clk);
      while (cyc < target && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      check("schedule", cyc, target);
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] rdv;
      logic        er;
      int          t0;
      int          tc;
      int          w;
      int          n;
      int          p;
      bit          ar;
      int          per;

      // Reset behaviour, including a bus access held during reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      psel = 1'b1; penable = 1'b1; paddr = 32'h08;
      #1;
      check("rst_pready", 32'(pready), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_pslverr", 32'(pslverr), 32'd0);
      psel = 1'b0; penable = 1'b0;
      #1;
      check("rst_prdata", prdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         apb_read(32'(i * 4), rdv, er, w);
         check($sformatf("reset_read_%0h", i * 4), rdv, 32'd0);
         check($sformatf("pslverr_%0h", i * 4), 32'(er), 32'(i >= 5));
      end

      // Wait states on a LOAD write, and LOAD copies into COUNT
      apb_write(32'h08, 32'h5, t0, w);
      check("load_waits", w, WS);
      apb_read(32'h08, rdv, er, w);
      check("read_waits", w, WS);
      check("load_rb", rdv, 32'h5);
      rd_check("count_rb", 32'h0C, 32'h5);

      // One-shot with interrupt enable
      wr(32'h04, 32'h0);
      wr(32'h08, 32'h3);
      apb_write(32'h00, 32'h5, t0, w);
      watch(t0, 3, 0, 1'b0, 1'b1, 8);
      rd_check("oneshot_ctrl", 32'h00, 32'h4);
      rd_check("oneshot_count", 32'h0C, 32'h0);

      // W1C drops irq on the cycle after the commit
      check("irq_before_w1c", 32'(irq), 32'd1);
      apb_write(32'h10, 32'h1, t0, w);
      @(negedge clk);
      check("irq_after_w1c", 32'(irq), 32'd0);
      rd_check("status_after_w1c", 32'h10, 32'h0);

      // Auto-reload, then a clear landing on the same edge as the next expiry
      wr(32'h04, 32'h1);
      wr(32'h08, 32'h2);
      apb_write(32'h00, 32'h3, t0, w);
      watch(t0, 2, 1, 1'b1, 1'b0, 7);
      wait_until(t0 + 7);
      apb_write(32'h10, 32'h1, tc, w);
      check("w1c_commit_edge", tc, t0 + 12);
      rd_check("set_beats_clear", 32'h10, 32'h1);
      wr(32'h00, 32'h0);
      wr(32'h10, 32'h1);
      rd_check("status_cleared", 32'h10, 32'h0);

      // Random register traffic: masking, read-only COUNT, ignored address bits
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         wr(($urandom & ~32'h1C) | 32'h04, d);
         rd_check("presc_rb", 32'h04, d & 32'hFFFF);
         wr(32'h08, d);
         rd_check("load_rand", 32'h08, d);
         wr(32'h0C, ~d);
         rd_check("count_ro", 32'h0C, d);
         wr(32'h00, d & 32'h6);
         rd_check("ctrl_rb", 32'h00, d & 32'h6);
         wr(32'h14 + 32'(4 * (i % 3)), d);
         rd_check("unmapped_rd", 32'h14 + 32'(4 * (i % 3)), 32'h0);
      end
      wr(32'h00, 32'h0);

      // Random timer runs against the period model
      for (int i = 0; i < 6; i++) begin
         n = $urandom_range(0, 5);
         p = $urandom_range(0, 3);
         ar = 1'($urandom_range(0, 1));
         per = (n + 1) * (p + 1);
         wr(32'h00, 32'h0);
         wr(32'h10, 32'h1);
         wr(32'h04, 32'(p));
         wr(32'h08, 32'(n));
         apb_write(32'h00, {29'b0, 1'b1, ar, 1'b1}, t0, w);
         watch(t0, n, p, ar, 1'b1, 2 * per + 2);
         rd_check("rand_ctrl", 32'h00, ar ? 32'h7 : 32'h4);
      end
      wr(32'h00, 32'h0);
      wr(32'h10, 32'h1);

      // psel dropped mid-wait: no commit, wait counter starts over
      wr(32'h08, 32'h11);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h22;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      apb_read(32'h08, rdv, er, w);
      check("abort_no_commit", rdv, 32'h11);
      check("abort_waits", w, WS);

      // Reset asserted on the completing ACCESS cycle of a LOAD write
      wr(32'h08, 32'h33);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hAA;
      @(posedge clk); #1;
      penable = 1'b1;
      repeat (WS) @(negedge clk);
      @(negedge clk);
      check("pready_before_rst", 32'(pready), 32'd1);
      rst_n = 1'b0;
      #1;
      check("pready_in_rst", 32'(pready), 32'd0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rd_check("load_after_rst", 32'h08, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
